// File: rtl/lr35902_int_pkg.sv
// lr35902_int_pkg: shared constants and FSM state type for the interrupt controller
package lr35902_int_pkg;
    localparam int SRC_VBLANK = 0;
    localparam int SRC_STAT   = 1;
    localparam int SRC_TIMER  = 2;
    localparam int SRC_SERIAL = 3;
    localparam int SRC_JOYPAD = 4;
    localparam logic ADR_IF = 1'b0;
    localparam logic ADR_IE = 1'b1;
    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;
endpackage

// File: rtl/lr35902_int_prio.sv
// lr35902_int_prio: lowest-index-first priority encoder over the pending vector
module lr35902_int_prio #(
    parameter int NSRC = 5,
    parameter int IW   = 3
) (
    input  logic [NSRC-1:0] i_pending,
    output logic            o_valid,
    output logic [IW-1:0]   o_idx,
    output logic [NSRC-1:0] o_mask
);
    assign o_valid = |i_pending;
    assign o_mask  = i_pending & (~i_pending + NSRC'(1));
    // scan downwards so the lowest set bit is the last (winning) assignment
    always_comb begin
        o_idx = '0;
        for (int k = NSRC - 1; k >= 0; k--)
            if (i_pending[k]) o_idx = IW'(k);
    end
endmodule

// File: rtl/lr35902_intctl.sv
// lr35902_intctl: IF/IE registers, IME and dispatch arbiter; optional wake output under LR35902_INTCTL_WAKE_EN
module lr35902_intctl
    import lr35902_int_pkg::*;
#(
    parameter int         NSRC       = 5,
    parameter logic [7:0] VEC_BASE   = 8'h40,
    parameter int         VEC_STRIDE = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NSRC-1:0] irq_src,
    output logic [7:0]      dout,
    input  logic [7:0]      din,
    input  logic            adr,
    input  logic            read,
    input  logic            write,
    input  logic            ime_set,
    input  logic            ime_clr,
    output logic            int_req,
    output logic [7:0]      int_vec,
    input  logic            int_ack,
    output logic            ime
`ifdef LR35902_INTCTL_WAKE_EN
    ,
    output logic            wake
`endif
);
    localparam int IW = $clog2(NSRC);

    logic [NSRC-1:0] r_if;
    logic [7:0]      r_ie;
    logic [7:0]      r_wdat;
    logic            r_wadr;
    logic            r_wp;
    logic            r_rd_d;
    logic            r_wr_d;
    logic            r_ime;
    logic            r_int_req;
    state_t          r_state;
    logic [NSRC-1:0] w_pend;
    logic [NSRC-1:0] w_mask;
    logic [NSRC-1:0] w_if_wr;
    logic [NSRC-1:0] w_if_nxt;
    logic            w_valid;
    logic            w_ack;
    logic [IW-1:0]   w_idx;

    lr35902_int_prio #(.NSRC(NSRC), .IW(IW)) u_prio (
        .i_pending(w_pend),
        .o_valid  (w_valid),
        .o_idx    (w_idx),
        .o_mask   (w_mask)
    );

    assign w_pend   = r_if & r_ie[NSRC-1:0];
    assign w_ack    = int_ack && (r_state == REQ);
    // write commit, then ack clear, then hardware set: a same-cycle pulse always survives
    assign w_if_wr  = (r_wp && r_wadr == ADR_IF) ? r_wdat[NSRC-1:0] : r_if;
    assign w_if_nxt = (w_if_wr & ~(w_ack ? w_mask : '0)) | irq_src;
    assign int_vec  = (r_state == REQ && w_valid) ? VEC_BASE + 8'(VEC_STRIDE) * 8'(w_idx) : 8'h00;
    assign int_req  = r_int_req;
    assign ime      = r_ime;

    // bus strobe edge detection, register file and IME
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_d <= 1'b0;
            r_wr_d <= 1'b0;
            r_wp   <= 1'b0;
            r_wadr <= 1'b0;
            r_wdat <= 8'h00;
            dout   <= 8'h00;
            r_if   <= '0;
            r_ie   <= 8'h00;
            r_ime  <= 1'b0;
        end else begin
            r_rd_d <= read;
            r_wr_d <= write;
            r_wp   <= !write && r_wr_d;
            if (!write && r_wr_d) begin
                r_wadr <= adr;
                r_wdat <= din;
            end
            if (read && !r_rd_d)
                dout <= (adr == ADR_IE) ? r_ie : {{(8-NSRC){1'b1}}, r_if};
            if (r_wp && r_wadr == ADR_IE)
                r_ie <= r_wdat;
            r_if  <= w_if_nxt;
            r_ime <= (ime_clr || w_ack) ? 1'b0 : (ime_set ? 1'b1 : r_ime);
        end
    end

    // dispatch FSM; SVC holds off re-request for one cycle after an ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_int_req <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (r_ime && w_valid) begin
                    r_state   <= REQ;
                    r_int_req <= 1'b1;
                end
                REQ: if (w_ack) begin
                    r_state   <= SVC;
                    r_int_req <= 1'b0;
                end else if (ime_clr) begin
                    r_state   <= IDLE;
                    r_int_req <= 1'b0;
                end
                SVC: r_state <= IDLE;
                default: begin
                    r_state   <= IDLE;
                    r_int_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef LR35902_INTCTL_WAKE_EN
    logic r_wake;
    // wake tracks any enabled pending source regardless of IME or dispatch state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_wake <= 1'b0;
        else          r_wake <= |w_pend;
    end
    assign wake = r_wake;
`endif
endmodule

// File: tb/tb_lr35902_intctl.sv
// tb_lr35902_intctl: table-driven register checks plus dispatch sequences, scoreboard-compared
module tb_lr35902_intctl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] irq_src = '0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic [7:0] int_vec;
    logic       adr = 1'b0;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic       ime_set = 1'b0;
    logic       ime_clr = 1'b0;
    logic       int_ack = 1'b0;
    logic       int_req;
    logic       ime;
`ifdef LR35902_INTCTL_WAKE_EN
    logic       wake;
`endif

    int n_pass = 0;
    int n_chk  = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic       a;
        logic [7:0] d;
        logic [7:0] e;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    lr35902_intctl dut (
        .clk    (clk),
        .reset_n(reset_n),
        .irq_src(irq_src),
        .dout   (dout),
        .din    (din),
        .adr    (adr),
        .read   (read),
        .write  (write),
        .ime_set(ime_set),
        .ime_clr(ime_clr),
        .int_req(int_req),
        .int_vec(int_vec),
        .int_ack(int_ack),
        .ime    (ime)
`ifdef LR35902_INTCTL_WAKE_EN
        ,
        .wake   (wake)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        sb.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [7:0] act);
        logic [7:0] e;
        n_chk++;
        if (sb.size() == 0) begin
            $display("FAIL %s: got %h, no expected value queued", nm, act);
            return;
        end
        e = sb.pop_front();
        if (act === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, e);
    endtask

    task automatic rd(input logic a);
        adr = a; read = 1'b1;
        tick;
        read = 1'b0;
        tick;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        adr = a; din = d; write = 1'b1;
        tick;
        write = 1'b0;
        tick;
        tick;
    endtask

    task automatic pulse_ime_set;
        ime_set = 1'b1;
        tick;
        ime_set = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'hFF, 8'hFF};
        tbl[1] = '{1'b0, 8'h1F, 8'hFF};
        tbl[2] = '{1'b0, 8'h0A, 8'hEA};
        tbl[3] = '{1'b0, 8'h00, 8'hE0};
        tbl[4] = '{1'b1, 8'hA5, 8'hA5};
        tbl[5] = '{1'b1, 8'h00, 8'h00};

        tick; tick;
        reset_n = 1'b1;
        tick;
        push(8'h00); chk("reset_dout", dout);
        push(8'h00); chk("reset_int_req", int_req);
        push(8'h00); chk("reset_int_vec", int_vec);
        push(8'h00); chk("reset_ime", ime);
        push(8'hE0); rd(1'b0); chk("reset_if", dout);
        push(8'h00); rd(1'b1); chk("reset_ie", dout);

        for (int i = 0; i < 6; i++) begin
            push(tbl[i].e);
            wr(tbl[i].a, tbl[i].d);
            rd(tbl[i].a);
            chk($sformatf("reg_rw_%0d", i), dout);
        end

        wr(1'b1, 8'h04);
        pulse_ime_set;
        push(8'h01); chk("timer_ime_on", ime);
        irq_src = 5'b00100;
        tick;
        irq_src = '0;
        push(8'h00); chk("timer_req_lat1", int_req);
        tick;
        push(8'h01); chk("timer_req_lat2", int_req);
        push(8'h50); chk("timer_vec", int_vec);
        int_ack = 1'b1;
        tick;
        int_ack = 1'b0;
        push(8'h00); chk("timer_ack_req", int_req);
        push(8'h00); chk("timer_ack_ime", ime);
        push(8'hE0); rd(1'b0); chk("timer_ack_if", dout);

        wr(1'b1, 8'h1F);
        wr(1'b0, 8'h12);
        pulse_ime_set;
        tick;
        push(8'h01); chk("prio_req", int_req);
        push(8'h48); chk("prio_vec_stat", int_vec);
        int_ack = 1'b1;
        tick;
        int_ack = 1'b0;
        pulse_ime_set;
        tick;
        push(8'h60); chk("prio_vec_joypad", int_vec);
        int_ack = 1'b1;
        tick;
        int_ack = 1'b0;
        tick;

        wr(1'b1, 8'h04);
        pulse_ime_set;
        irq_src = 5'b00100;
        tick;
        irq_src = '0;
        tick;
        push(8'h50); chk("cancel_vec_before", int_vec);
        wr(1'b0, 8'h00);
        push(8'h00); chk("cancel_vec_after", int_vec);
        push(8'h01); chk("cancel_req_held", int_req);
        int_ack = 1'b1;
        tick;
        int_ack = 1'b0;
        push(8'h00); chk("cancel_ack_ime", ime);
        push(8'hE0); rd(1'b0); chk("cancel_if", dout);

        adr = 1'b0; din = 8'h00; write = 1'b1;
        tick;
        write = 1'b0;
        tick;
        irq_src = 5'b00001;
        tick;
        irq_src = '0;
        push(8'hE1); rd(1'b0); chk("hw_set_wins", dout);
        pulse_ime_set;
        push(8'h01); chk("ime_set_alone", ime);
        ime_set = 1'b1; ime_clr = 1'b1;
        tick;
        ime_set = 1'b0; ime_clr = 1'b0;
        push(8'h00); chk("ime_clr_wins", ime);

        wr(1'b1, 8'h01);
        pulse_ime_set;
        tick;
        push(8'h40); chk("arst_vec_before", int_vec);
        #2;
        reset_n = 1'b0;
        #1;
        push(8'h00); chk("arst_int_req", int_req);
        push(8'h00); chk("arst_int_vec", int_vec);
        push(8'h00); chk("arst_ime", ime);
        tick;
        reset_n = 1'b1;
        tick;
        push(8'hE0); rd(1'b0); chk("arst_if", dout);
        push(8'h00); rd(1'b1); chk("arst_ie", dout);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
